ka283_seq_ctrl: RTL and testbench

Sequencing controller that computes a 283×283-bit GF(2) polynomial product through one shared external 142-bit Karatsuba multiplier core, instead of three parallel core instances. It accepts operand pairs over a valid/ready handshake, issues the three Karatsuba sub-products (low, high, middle) to the core back-to-back, and accumulates the returned partials. It then applies the 142/284-bit overlap combine and returns the 565-bit product over a valid/ready handshake. It sits between the field-arithmetic front end and the shared KA_142bit core.

---
 rtl/ka283_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_ka283_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ka283_seq_ctrl.sv
// 283x283-bit GF(2) multiplier sequencer driving one shared 142-bit Karatsuba core.
// Define KA283_REDUCE_EN to add a REDUCE state that folds the product mod x^283+x^12+x^7+x^5+1.
module ka283_seq_ctrl #(
  parameter int CORE_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [282:0] in_a,
  input  logic [282:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [564:0] out_y,
  output logic [141:0] core_a,
  output logic [141:0] core_b,
  output logic         core_start,
  input  logic [282:0] core_y,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, DRAIN, COMBINE, REDUCE, DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_P0, TAG_P2, TAG_P1} tag_t;

  state_t        state, next_state;
  tag_t          issue_tag, ret_tag;
  logic [282:0]  a_q, b_q;
  logic [282:0]  p0_q, p1_q, p2_q;
  logic [282:0]  mid;
  logic [566:0]  wide_y;

  // Upper halves are 141 bits; zero-extend to the core's 142-bit operand width.
  logic [141:0] a_lo, a_hi, b_lo, b_hi;
  assign a_lo = a_q[141:0];
  assign b_lo = b_q[141:0];
  assign a_hi = {1'b0, a_q[282:142]};
  assign b_hi = {1'b0, b_q[282:142]};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    core_a     = '0;
    core_b     = '0;
    core_start = 1'b0;
    issue_tag  = TAG_NONE;
    case (state)
      MUL0: begin
        core_a = a_lo; core_b = b_lo; core_start = 1'b1; issue_tag = TAG_P0;
      end
      MUL1: begin
        core_a = a_hi; core_b = b_hi; core_start = 1'b1; issue_tag = TAG_P2;
      end
      MUL2: begin
        core_a = a_lo ^ a_hi; core_b = b_lo ^ b_hi; core_start = 1'b1; issue_tag = TAG_P1;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = MUL0;
      MUL0:    next_state = MUL1;
      MUL1:    next_state = MUL2;
      MUL2:    next_state = (CORE_LAT == 0) ? COMBINE : DRAIN;
      DRAIN:   if (ret_tag == TAG_P1) next_state = COMBINE;
`ifdef KA283_REDUCE_EN
      COMBINE: next_state = REDUCE;
      REDUCE:  next_state = DONE;
`else
      COMBINE: next_state = DONE;
`endif
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Tag pipe mirrors the core latency so each returning product lands in the right partial.
  generate
    if (CORE_LAT == 0) begin : g_comb_core
      assign ret_tag = issue_tag;
    end else begin : g_tag_pipe
      tag_t tag_pipe [CORE_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this small array is reset on purpose; stale tags would capture in-flight returns of an aborted job.
        if (!rst_n) begin
          for (int i = 0; i < CORE_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
          tag_pipe[0] <= issue_tag;
          for (int i = 1; i < CORE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
      end
      assign ret_tag = tag_pipe[CORE_LAT-1];
    end
  endgenerate

  assign mid    = p0_q ^ p1_q ^ p2_q;
  assign wide_y = {284'd0, p0_q} ^ ({284'd0, mid} << 142) ^ ({284'd0, p2_q} << 284);

`ifdef KA283_REDUCE_EN
  // Two folds of x^283 = x^12+x^7+x^5+1; the second fold's overflow is at most 11 bits.
  function automatic logic [282:0] reduce_b283(input logic [564:0] c);
    logic [281:0] hi;
    logic [293:0] t;
    logic [10:0]  h2;
    hi = c[564:283];
    t  = {11'd0, c[282:0]} ^ {12'd0, hi} ^ ({12'd0, hi} << 5)
       ^ ({12'd0, hi} << 7) ^ ({12'd0, hi} << 12);
    h2 = t[293:283];
    return t[282:0] ^ {272'd0, h2} ^ ({272'd0, h2} << 5)
         ^ ({272'd0, h2} << 7) ^ ({272'd0, h2} << 12);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      p0_q  <= '0;
      p1_q  <= '0;
      p2_q  <= '0;
      out_y <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      case (ret_tag)
        TAG_P0:  p0_q <= core_y;
        TAG_P2:  p2_q <= core_y;
        TAG_P1:  p1_q <= core_y;
        default: ;
      endcase
      if (state == COMBINE) out_y <= wide_y[564:0];
`ifdef KA283_REDUCE_EN
      if (state == REDUCE) out_y <= {282'd0, reduce_b283(out_y)};
`endif
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ka283_seq_ctrl.sv
// Bench for ka283_seq_ctrl: three instances (CORE_LAT 0, 1, 2) share stimulus, each with its own core model.
// Checks products against a schoolbook GF(2) model, latency, core issue pattern, backpressure and reset abort.
`timescale 1ns/1ps
module tb_ka283_seq_ctrl;

  localparam int NDUT = 3;
`ifdef KA283_REDUCE_EN
  localparam int RED = 1;
`else
  localparam int RED = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, in_valid, out_ready;
  logic [282:0]       in_a, in_b;
  logic [NDUT-1:0]    in_ready_v, out_valid_v, core_start_v, busy_v;
  logic [564:0]       out_y_v    [NDUT];
  logic [141:0]       core_a_v   [NDUT];
  logic [141:0]       core_b_v   [NDUT];
  logic [282:0]       core_y_v   [NDUT];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [282:0] rnd283();
    logic [287:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return r[282:0];
  endfunction

  function automatic logic [282:0] clmul142(input logic [141:0] a, input logic [141:0] b);
    logic [282:0] r;
    r = '0;
    for (int i = 0; i < 142; i++) if (b[i]) r ^= {141'd0, a} << i;
    return r;
  endfunction

  // Reference: plain shift-and-xor product, then long division by the B-283 polynomial.
  function automatic logic [564:0] ref_mul(input logic [282:0] a, input logic [282:0] b);
    logic [564:0] r;
    r = '0;
    for (int i = 0; i < 283; i++) if (b[i]) r ^= {282'd0, a} << i;
    return r;
  endfunction

  function automatic logic [564:0] ref_reduce(input logic [564:0] c);
    logic [564:0] r, f;
    r = c;
    f = '0;
    f[283] = 1'b1; f[12] = 1'b1; f[7] = 1'b1; f[5] = 1'b1; f[0] = 1'b1;
    for (int i = 564; i >= 283; i--) if (r[i]) r ^= f << (i - 283);
    return r;
  endfunction

  function automatic logic [564:0] expect_y(input logic [282:0] a, input logic [282:0] b);
    return (RED != 0) ? ref_reduce(ref_mul(a, b)) : ref_mul(a, b);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ka283_seq_ctrl #(.CORE_LAT(g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready_v[g]),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid_v[g]),
      .out_ready  (out_ready),
      .out_y      (out_y_v[g]),
      .core_a     (core_a_v[g]),
      .core_b     (core_b_v[g]),
      .core_start (core_start_v[g]),
      .core_y     (core_y_v[g]),
      .busy       (busy_v[g])
    );
    if (g == 0) begin : g_comb
      assign core_y_v[g] = clmul142(core_a_v[g], core_b_v[g]);
    end else begin : g_reg
      // Pipelined core model; idle slots return junk so only tagged captures matter.
      logic [282:0] stage [g];
      always @(posedge clk) begin
        stage[0] <= core_start_v[g] ? clmul142(core_a_v[g], core_b_v[g]) : rnd283();
        for (int i = 1; i < g; i++) stage[i] <= stage[i-1];
      end
      assign core_y_v[g] = stage[g-1];
    end
  end

  task automatic check(input string name, input logic [564:0] got, input logic [564:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    while (in_ready_v != {NDUT{1'b1}} && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s idle", tag), 565'(in_ready_v), 565'(3'b111));
  endtask

  // Accept one job on all instances and record, per instance, first out_valid cycle,
  // out_y at that cycle and the cycles in which core_start was high (edge 0 = acceptance).
  task automatic run_job(input string tag, input logic [282:0] a, input logic [282:0] b,
                         input logic [564:0] exp);
    int           seen_cyc   [NDUT];
    logic [564:0] seen_y     [NDUT];
    logic [7:0]   start_mask [NDUT];
    int           n_seen;
    wait_idle(tag);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    check($sformatf("%s busy", tag), 565'(busy_v), 565'(3'b111));
    for (int g = 0; g < NDUT; g++) begin
      seen_cyc[g] = 0; seen_y[g] = '0; start_mask[g] = '0;
    end
    n_seen = 0;
    for (int cyc = 1; cyc <= 30 && n_seen < NDUT; cyc++) begin
      for (int g = 0; g < NDUT; g++) begin
        if (core_start_v[g]) start_mask[g][(cyc < 8) ? cyc : 0] = 1'b1;
        if (out_valid_v[g] && seen_cyc[g] == 0) begin
          seen_cyc[g] = cyc;
          seen_y[g]   = out_y_v[g];
          n_seen++;
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s lat%0d valid_cycle", tag, g), 565'(seen_cyc[g]), 565'(5 + g + RED));
      check($sformatf("%s lat%0d out_y", tag, g), seen_y[g], exp);
      check($sformatf("%s lat%0d core_start", tag, g), 565'(start_mask[g]), 565'(8'b0000_1110));
    end
  endtask

  typedef struct {
    logic [282:0] a;
    logic [282:0] b;
    logic [564:0] y_full;
    logic [564:0] y_red;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [282:0] a, b;
    logic [564:0] exp;
    logic [NDUT-1:0] ov_or;
    int waited;

    vecs[0].a = 283'd1;            vecs[0].b = 283'd1;
    vecs[0].y_full = 565'd1;       vecs[0].y_red = 565'd1;
    vecs[1].a = 283'd1 << 282;     vecs[1].b = 283'd1 << 282;
    vecs[1].y_full = 565'd1 << 564;
    vecs[1].y_red  = ref_reduce(565'd1 << 564);
    vecs[2].a = (283'd1 << 141) | 283'd1;  vecs[2].b = (283'd1 << 141) | 283'd1;
    vecs[2].y_full = (565'd1 << 282) | 565'd1;  vecs[2].y_red = (565'd1 << 282) | 565'd1;
    vecs[3].a = '1;                vecs[3].b = 283'd1;
    vecs[3].y_full = {282'd0, {283{1'b1}}};     vecs[3].y_red = {282'd0, {283{1'b1}}};
    vecs[4].a = 283'd1 << 282;     vecs[4].b = 283'd2;
    vecs[4].y_full = 565'd1 << 283;             vecs[4].y_red = 565'h10A1;
    vecs[5].a = 283'd3;            vecs[5].b = 283'd3;
    vecs[5].y_full = 565'd5;       vecs[5].y_red = 565'd5;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 565'(in_ready_v), 565'(0));
    check("reset flags", 565'({out_valid_v, busy_v, core_start_v}), 565'(0));
    check("reset out_y", out_y_v[1], 565'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset in_ready", 565'(in_ready_v), 565'(3'b111));

    for (int i = 0; i < NV; i++)
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              (RED != 0) ? vecs[i].y_red : vecs[i].y_full);

    for (int i = 0; i < 20; i++) begin
      a = rnd283(); b = rnd283();
      if (i % 4 == 1) a = 283'd1 << $urandom_range(282, 0);
      if (i % 4 == 2) b = b & ~(283'd0) >> $urandom_range(282, 0);
      run_job($sformatf("rnd%0d", i), a, b, expect_y(a, b));
    end

    // Backpressure: consumer stalls 10 cycles while a new request is offered.
    wait_idle("bp");
    out_ready = 1'b0;
    a = rnd283(); b = rnd283(); exp = expect_y(a, b);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (out_valid_v != {NDUT{1'b1}} && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("bp all valid", 565'(out_valid_v), 565'(3'b111));
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_a = rnd283(); in_b = rnd283();
      for (int g = 0; g < NDUT; g++)
        check($sformatf("bp k%0d lat%0d out_y", k, g), out_y_v[g], exp);
      check($sformatf("bp k%0d valid/busy/ready", k),
            565'({out_valid_v, busy_v, in_ready_v}), 565'(9'b111_111_000));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp release", 565'({out_valid_v, busy_v, in_ready_v}), 565'(9'b000_000_111));
    @(negedge clk);
    check("bp single handshake", 565'({out_valid_v, busy_v, in_ready_v}), 565'(9'b000_000_111));

    // Reset during MUL2 discards the job, including in-flight core returns.
    wait_idle("rst");
    in_a = rnd283(); in_b = rnd283(); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst in MUL2 core_start", 565'(core_start_v), 565'(3'b111));
    rst_n = 1'b0;
    #1;
    check("rst flags", 565'({out_valid_v, busy_v, core_start_v, in_ready_v}), 565'(0));
    check("rst core_a", 565'(core_a_v[2]), 565'(0));
    check("rst core_b", 565'(core_b_v[2]), 565'(0));
    check("rst out_y", out_y_v[2], 565'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ov_or = '0;
    repeat (12) begin
      @(negedge clk);
      ov_or |= out_valid_v;
    end
    check("rst no stray out_valid", 565'(ov_or), 565'(0));
    run_job("post_rst", 283'd3, 283'd3, 565'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
